// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-RAM arbiter.
//   arb_state_t      : arbiter FSM encoding (ARB_S, HOST_BURST_S)
//   REQ_CPU/REQ_HOST : requester IDs carried in the read-return tag
//   DEFAULT_MAX_WAIT : default host starvation limit
//   WAIT_W           : width of the host wait counter (MAX_WAIT range 1..15)
package dmem_arbiter_pkg;

  typedef enum logic {
    ARB_S        = 1'b0,
    HOST_BURST_S = 1'b1
  } arb_state_t;

  localparam logic REQ_CPU  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

  localparam int DEFAULT_MAX_WAIT = 4;
  localparam int WAIT_W           = 4;

endpackage

// File: rtl/dmem_rd_tag.sv
// Read-return tag and rdata/rvalid steering for a synchronous RAM.
// A read issued in one enabled cycle returns in the next enabled cycle;
// the tag remembers which requester issued it.
//   i_clk, i_rst, i_clk_en : clock, sync active-high reset, clock enable
//   i_rd_issue, i_rd_id    : a read was granted this cycle, and to whom
//   i_ram_rdata            : RAM read data (valid the cycle after the read)
//   o_rvalid[i], o_rdata[i]: per-requester return; rdata is 0 when not valid
module dmem_rd_tag #(
  parameter int DW   = 32,
  parameter int NREQ = 2,
  parameter int ID_W = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clk_en,
  input  logic                      i_rd_issue,
  input  logic [ID_W-1:0]           i_rd_id,
  input  logic [DW-1:0]             i_ram_rdata,
  output logic [NREQ-1:0]           o_rvalid,
  output logic [NREQ-1:0][DW-1:0]   o_rdata
);

  logic            tag_valid_q;
  logic [ID_W-1:0] tag_id_q;
  logic            live;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag_valid_q <= 1'b0;
      tag_id_q    <= '0;
    end else if (i_clk_en) begin
      tag_valid_q <= i_rd_issue;
      tag_id_q    <= i_rd_id;
    end
  end

  // The tag holds across disabled cycles, so the return is masked there and
  // reappears on the next enabled cycle. Reset discards it immediately.
  assign live = tag_valid_q & i_clk_en & ~i_rst;

  always_comb begin
    o_rvalid = '0;
    o_rdata  = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_rvalid[i] = live && (tag_id_q == ID_W'(i));
      o_rdata[i]  = o_rvalid[i] ? i_ram_rdata : '0;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing the single-port data RAM between the CPU data port
// (fixed priority) and the host/debug loader port.
//   CPU port  : i_cpu_req/we/addr/wdata -> o_cpu_gnt, o_cpu_stall,
//               o_cpu_rvalid, o_cpu_rdata
//   Host port : i_host_req/we/lock/addr/wdata -> o_host_gnt, o_host_rvalid,
//               o_host_rdata
//   RAM port  : o_ram_cs/we/addr/wdata, i_ram_rdata (synchronous read)
//   Debug     : o_dbg_state, o_dbg_host_wait expose the FSM state and the
//               starvation counter
// Handshake: a grant is a same-cycle acceptance; the requester's inputs go
// straight to the RAM in the granted cycle. Read data returns with a
// one-cycle rvalid in the next enabled cycle. No backpressure on returns.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clk_en,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [AW-1:0]     i_cpu_addr,
  input  logic [DW-1:0]     i_cpu_wdata,
  output logic              o_cpu_gnt,
  output logic              o_cpu_stall,
  output logic              o_cpu_rvalid,
  output logic [DW-1:0]     o_cpu_rdata,
  input  logic              i_host_req,
  input  logic              i_host_we,
  input  logic              i_host_lock,
  input  logic [AW-1:0]     i_host_addr,
  input  logic [DW-1:0]     i_host_wdata,
  output logic              o_host_gnt,
  output logic              o_host_rvalid,
  output logic [DW-1:0]     o_host_rdata,
  output logic              o_ram_cs,
  output logic              o_ram_we,
  output logic [AW-1:0]     o_ram_addr,
  output logic [DW-1:0]     o_ram_wdata,
  input  logic [DW-1:0]     i_ram_rdata,
  output arb_state_t        o_dbg_state,
  output logic [WAIT_W-1:0] o_dbg_host_wait
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              cpu_gnt, host_gnt;
  logic              rd_issue;
  logic [1:0]        rvalid_vec;
  logic [1:0][DW-1:0] rdata_vec;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ARB_S;
      wait_q  <= '0;
    end else if (i_clk_en) begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    state_d  = state_q;
    wait_d   = wait_q;

    if (i_clk_en && !i_rst) begin
      // Dropping the lock in HOST_BURST releases the RAM in that same cycle,
      // so it falls through to normal arbitration.
      if (state_q == HOST_BURST_S && i_host_lock) begin
        host_gnt = i_host_req;
      end else if (i_host_req && wait_q == WAIT_MAX) begin
        host_gnt = 1'b1;
      end else if (i_cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (i_host_req) begin
        host_gnt = 1'b1;
      end
    end

    if (i_host_lock && (host_gnt || state_q == HOST_BURST_S)) begin
      state_d = HOST_BURST_S;
    end else begin
      state_d = ARB_S;
    end

    if (!i_host_req || host_gnt) begin
      wait_d = '0;
    end else if (wait_q != WAIT_MAX) begin
      wait_d = wait_q + 1'b1;
    end
  end

  assign o_cpu_gnt   = cpu_gnt;
  assign o_host_gnt  = host_gnt;
  assign o_cpu_stall = i_cpu_req & ~cpu_gnt & ~i_rst;

  always_comb begin
    o_ram_cs    = cpu_gnt | host_gnt;
    o_ram_we    = 1'b0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    if (cpu_gnt) begin
      o_ram_we    = i_cpu_we;
      o_ram_addr  = i_cpu_addr;
      o_ram_wdata = i_cpu_wdata;
    end else if (host_gnt) begin
      o_ram_we    = i_host_we;
      o_ram_addr  = i_host_addr;
      o_ram_wdata = i_host_wdata;
    end
  end

  assign rd_issue = (cpu_gnt & ~i_cpu_we) | (host_gnt & ~i_host_we);

  dmem_rd_tag #(
    .DW   (DW),
    .NREQ (2),
    .ID_W (1)
  ) u_rd_tag (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_clk_en    (i_clk_en),
    .i_rd_issue  (rd_issue),
    .i_rd_id     (host_gnt ? REQ_HOST : REQ_CPU),
    .i_ram_rdata (i_ram_rdata),
    .o_rvalid    (rvalid_vec),
    .o_rdata     (rdata_vec)
  );

  assign o_cpu_rvalid  = rvalid_vec[REQ_CPU];
  assign o_cpu_rdata   = rdata_vec[REQ_CPU];
  assign o_host_rvalid = rvalid_vec[REQ_HOST];
  assign o_host_rdata  = rdata_vec[REQ_HOST];

  assign o_dbg_state     = state_q;
  assign o_dbg_host_wait = wait_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a behavioural RAM, a per-cycle reference model of
// the arbitration rules, and a read-return scoreboard drained by a monitor.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int AW = 24;
  localparam int DW = 32;
  localparam int MAX_WAIT = 4;
  localparam int W = DW + 1;  // {id, data}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, clk_en;
  logic cpu_req, cpu_we, host_req, host_we, host_lock;
  logic [AW-1:0] cpu_addr, host_addr;
  logic [DW-1:0] cpu_wdata, host_wdata;
  logic cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
  logic [DW-1:0] cpu_rdata, host_rdata;
  logic ram_cs, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
  arb_state_t dbg_state;
  logic [WAIT_W-1:0] dbg_wait;

  dmem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(clk), .i_rst(rst), .i_clk_en(clk_en),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall),
    .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_lock(host_lock),
    .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid),
    .o_host_rdata(host_rdata),
    .o_ram_cs(ram_cs), .o_ram_we(ram_we), .o_ram_addr(ram_addr),
    .o_ram_wdata(ram_wdata), .i_ram_rdata(ram_rdata),
    .o_dbg_state(dbg_state), .o_dbg_host_wait(dbg_wait)
  );

  // Behavioural synchronous single-port RAM (depth truncation to 1K words).
  logic [DW-1:0] ram [0:1023];
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_we) ram[ram_addr[9:0]] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr[9:0]];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  int n_tests = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [0:1023];
  int  starve = 0;         // consecutive cycles the host has been refused
  bit  burst = 0;          // host currently owns the RAM
  bit  model_known = 0;    // DUT registers defined (after first reset edge)
  bit  pend_valid = 0;
  logic [W-1:0] pend_val;
  bit  last_exp_host, last_act_cpu;
  int  host_gnt_seen, cpu_gnt_seen;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Called right after a negedge with inputs already driven; checks the
  // cycle, advances the model, and returns at the next negedge.
  task automatic step();
    bit e_cpu, e_host, e_we, e_stall;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    arb_state_t e_state;
    #1;
    e_cpu = 0; e_host = 0;
    if (!rst && clk_en) begin
      if (burst && host_lock)                     e_host = host_req;
      else if (host_req && starve == MAX_WAIT)    e_host = 1;
      else if (cpu_req)                           e_cpu = 1;
      else if (host_req)                          e_host = 1;
    end
    e_we = 0; e_addr = '0; e_wdata = '0;
    if (e_cpu)  begin e_we = cpu_we;  e_addr = cpu_addr;  e_wdata = cpu_wdata;  end
    if (e_host) begin e_we = host_we; e_addr = host_addr; e_wdata = host_wdata; end
    e_stall = cpu_req && !e_cpu && !rst;
    e_state = burst ? HOST_BURST_S : ARB_S;

    check("grant", {61'd0, cpu_gnt, host_gnt, cpu_stall}, {61'd0, e_cpu, e_host, e_stall});
    check("ram_bus", {6'd0, ram_cs, ram_we, ram_addr, ram_wdata},
          {6'd0, e_cpu | e_host, e_we, e_addr, e_wdata});
    if (model_known)
      check("state", {59'd0, dbg_state, dbg_wait}, {59'd0, e_state, WAIT_W'(starve)});

    last_exp_host = e_host;
    last_act_cpu  = cpu_gnt;
    host_gnt_seen += int'(host_gnt);
    cpu_gnt_seen  += int'(cpu_gnt);

    pend_valid = 0;
    if (e_cpu || e_host) begin
      if (e_we) ref_mem[e_addr[9:0]] = e_wdata;
      else begin
        pend_valid = 1;
        pend_val = {e_host, ref_mem[e_addr[9:0]]};
      end
    end

    if (rst) begin
      starve = 0; burst = 0; model_known = 1;
      exp_q.delete();
    end else if (clk_en) begin
      if (host_req && !e_host) starve = (starve < MAX_WAIT) ? starve + 1 : MAX_WAIT;
      else starve = 0;
      burst = host_lock && (e_host || burst);
    end
    @(negedge clk);
    if (pend_valid) exp_q.push_back(pend_val);
  endtask

  // Monitor: pops the expected read return whenever the DUT presents one.
  always @(negedge clk) begin
    logic [W-1:0] exp;
    #3;
    if (cpu_rvalid || host_rvalid) begin
      if (cpu_rvalid && host_rvalid) begin
        check("rvalid_onehot", {62'd0, cpu_rvalid, host_rvalid}, 64'd1);
      end else if (exp_q.size() == 0) begin
        check("rvalid_unexpected", {62'd0, cpu_rvalid, host_rvalid}, 64'd0);
      end else begin
        exp = exp_q.pop_front();
        check("rdata", {31'd0, host_rvalid, host_rvalid ? host_rdata : cpu_rdata},
              {31'd0, exp});
        check("rdata_idle", {32'd0, host_rvalid ? cpu_rdata : host_rdata}, 64'd0);
      end
    end else if (clk_en && !rst && exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      check("rvalid_missing", 64'd0, {63'd0, 1'b1});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    cpu_req = req; cpu_we = we; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic set_host(input logic req, input logic we, input logic lock,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    host_req = req; host_we = we; host_lock = lock; host_addr = a; host_wdata = d;
  endtask

  initial begin
    int tries;
    rst = 1; clk_en = 1;
    set_cpu(0, 0, '0, '0);
    set_host(0, 0, 0, '0, '0);
    @(negedge clk);
    repeat (3) step();
    rst = 0;
    step();

    // Preload: host writes the working set used by all later reads.
    for (int a = 0; a < 48; a++) begin
      set_host(1, 1, 0, AW'(a), $urandom());
      step();
    end
    set_host(0, 0, 0, '0, '0);

    // CPU only: write then read back.
    set_cpu(1, 1, 24'h000010, 32'h12345678); step();
    set_cpu(1, 0, 24'h000010, '0);           step();
    set_cpu(0, 0, '0, '0);                   step(); step();

    // Contention: 4 CPU grants then 1 forced host grant, repeating.
    host_gnt_seen = 0; cpu_gnt_seen = 0;
    set_cpu(1, 0, 24'h000005, '0);
    set_host(1, 0, 0, 24'h000006, '0);
    repeat (20) step();
    check("starve_host_grants", 64'(host_gnt_seen), 64'd4);
    check("starve_cpu_grants", 64'(cpu_gnt_seen), 64'd16);
    set_cpu(0, 0, '0, '0); set_host(0, 0, 0, '0, '0); step();

    // Host burst of 8 writes against continuous CPU requests.
    set_cpu(1, 0, 24'h000005, '0);
    for (int i = 0; i < 8; i++) begin
      set_host(1, 1, 1, 24'h000100 + AW'(i), $urandom());
      tries = 0;
      do begin step(); tries++; end while (!last_exp_host && tries < 10);
      check("burst_word_granted", {63'd0, last_exp_host}, 64'd1);
    end
    set_host(0, 0, 0, '0, '0);
    set_cpu(1, 0, 24'h000103, '0);
    step();
    check("burst_release_cpu", {63'd0, last_act_cpu}, 64'd1);
    set_cpu(0, 0, '0, '0); step(); step();

    // Interleaved reads CPU / host / CPU.
    set_cpu(1, 0, 24'h000020, '0); step();
    set_cpu(0, 0, '0, '0); set_host(1, 0, 0, 24'h000021, '0); step();
    set_cpu(1, 0, 24'h000022, '0); set_host(0, 0, 0, '0, '0); step();
    set_cpu(0, 0, '0, '0); step(); step();

    // Clock-enable gap with a host read outstanding.
    set_host(1, 0, 0, 24'h000007, '0); step();
    clk_en = 0; set_cpu(1, 0, 24'h000003, '0);
    repeat (3) step();
    clk_en = 1; set_cpu(0, 0, '0, '0); set_host(0, 0, 0, '0, '0);
    step(); step();

    // Reset in HOST_BURST with a read in flight.
    set_host(1, 0, 1, 24'h000008, '0); step();
    rst = 1; step();
    rst = 0; set_host(0, 0, 0, '0, '0); step();
    set_cpu(1, 0, 24'h000009, '0); set_host(1, 0, 0, 24'h00000a, '0); step();
    check("post_reset_cpu_first", {63'd0, last_act_cpu}, 64'd1);
    set_cpu(0, 0, '0, '0); set_host(0, 0, 0, '0, '0); step(); step();

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      clk_en = ($urandom_range(0, 9) != 0);
      rst    = ($urandom_range(0, 99) == 0);
      set_cpu($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
              AW'($urandom_range(0, 47)), $urandom());
      set_host($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
               host_lock ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0),
               AW'($urandom_range(0, 47)), $urandom());
      step();
    end
    rst = 0; clk_en = 1;
    set_cpu(0, 0, '0, '0); set_host(0, 0, 0, '0, '0);
    repeat (3) step();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
